artix_spi_master: RTL and testbench

// - SPI master between the PS AXI-Lite register block and the Artix front-end FPGA.
// - Software writes addr, data and a go-bit; the block serialises one 32-bit frame
//   {rnw, addr[6:0], data[23:0]}, MSB first, SPI mode 0.
// - On reads it captures the 24-bit MISO data phase and returns it for the status

---
 rtl/artix_spi_pkg.sv | 17 +
 rtl/artix_spi_master_if.sv | 25 ++
 rtl/spi_sclk_div.sv | 37 +++
 rtl/artix_spi_master.sv | 143 ++++++++++++++
 tb/tb_artix_spi_master.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/artix_spi_pkg.sv
// rtl/artix_spi_pkg.sv - frame geometry and FSM state type for the Artix SPI master
package artix_spi_pkg;

    localparam int FRAME_W = 32;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 24;
    localparam int RNW_BIT = 31;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_state_t;

endpackage

// File: rtl/artix_spi_master_if.sv
// rtl/artix_spi_master_if.sv - register-bank side of the Artix SPI master
interface artix_spi_master_if;
    import artix_spi_pkg::*;

    logic                strobe_i;
    logic                rnw_i;
    logic [ADDR_W-1:0]   addr_i;
    logic [DATA_W-1:0]   wdata_i;
    logic                busy_o;
    logic                done_o;
    logic [FRAME_W-1:0]  rdata_o;
    logic                overrun_o;

    // master = register bank, slave = SPI engine
    modport master (
        output strobe_i, rnw_i, addr_i, wdata_i,
        input  busy_o, done_o, rdata_o, overrun_o
    );

    modport slave (
        input  strobe_i, rnw_i, addr_i, wdata_i,
        output busy_o, done_o, rdata_o, overrun_o
    );

endinterface

// File: rtl/spi_sclk_div.sv
// rtl/spi_sclk_div.sv - SCLK half-period divider producing rise/fall ticks while enabled
module spi_sclk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic en,
    output logic rise_tick,
    output logic fall_tick
);
    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] cnt;
    logic             phase;
    logic             term;

    // phase 0 = SCLK low half, phase 1 = SCLK high half
    assign term      = en && (cnt == DIV_W'(CLK_DIV - 1));
    assign rise_tick = term && !phase;
    assign fall_tick = term && phase;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (term) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/artix_spi_master.sv
// rtl/artix_spi_master.sv - SPI mode 0 master serialising {rnw, addr, data} frames to the Artix
module artix_spi_master
    import artix_spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic               aclk,
    input  logic               aresetn,
    artix_spi_master_if.slave  regs,
    output logic               spi_sclk_o,
    output logic               spi_cs_n_o,
    output logic               spi_mosi_o,
    input  logic               spi_miso_i
);
    localparam int CNT_W = 16;
    localparam int BIT_W = $clog2(FRAME_W);

    spi_state_t          state;
    logic [CNT_W-1:0]    cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [FRAME_W-1:0]  shreg;
    logic [DATA_W-1:0]   capture;
    logic [FRAME_W-1:0]  rdata;
    logic                rnw_q;
    logic                strobe_q;
    logic                launch;
    logic                busy;
    logic                done;
    logic                overrun;
    logic                rise_tick;
    logic                fall_tick;

    assign launch = regs.strobe_i & ~strobe_q;

    spi_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_div (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .en        (state == SHIFT),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            capture    <= '0;
            rdata      <= '0;
            rnw_q      <= 1'b0;
            strobe_q   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
            spi_sclk_o <= 1'b0;
            spi_cs_n_o <= 1'b1;
            spi_mosi_o <= 1'b0;
        end else begin
            strobe_q <= regs.strobe_i;
            unique case (state)
                IDLE: begin
                    if (launch) begin
                        shreg      <= {regs.rnw_i, regs.addr_i, regs.wdata_i};
                        rnw_q      <= regs.rnw_i;
                        spi_mosi_o <= regs.rnw_i;
                        spi_cs_n_o <= 1'b0;
                        busy       <= 1'b1;
                        overrun    <= 1'b0;
                        cnt        <= '0;
                        bit_cnt    <= '0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == CNT_W'(CS_SETUP - 1)) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (rise_tick) begin
                        spi_sclk_o <= 1'b1;
                        capture    <= {capture[DATA_W-2:0], spi_miso_i};
                    end
                    // MOSI only moves on falling edges so the slave samples a stable bit
                    if (fall_tick) begin
                        spi_sclk_o <= 1'b0;
                        shreg      <= {shreg[FRAME_W-2:0], 1'b0};
                        spi_mosi_o <= shreg[FRAME_W-2];
                        bit_cnt    <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (cnt == CNT_W'(CS_HOLD - 1)) begin
                        cnt        <= '0;
                        spi_cs_n_o <= 1'b1;
                        spi_mosi_o <= 1'b0;
                        state      <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    cnt <= cnt + 1'b1;
                    // done and rdata become visible together in the final gap cycle
                    if (cnt == CNT_W'(CS_GAP - 2)) begin
                        done <= 1'b1;
                        if (rnw_q) begin
                            rdata <= {{(FRAME_W - DATA_W){1'b0}}, capture};
                        end
                    end
                    if (cnt == CNT_W'(CS_GAP - 1)) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (launch && busy) begin
                overrun <= 1'b1;
            end
        end
    end

    assign regs.busy_o    = busy;
    assign regs.done_o    = done;
    assign regs.rdata_o   = rdata;
    assign regs.overrun_o = overrun;

endmodule

// File: tb/tb_artix_spi_master.sv
// tb/tb_artix_spi_master.sv - scoreboard bench for artix_spi_master with a mode 0 slave model
module tb_artix_spi_master;
    import artix_spi_pkg::*;

    localparam int PERIOD      = 10;
    localparam int BUSY_CYCLES = 264;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso    = 1'b0;

    artix_spi_master_if regs();

    artix_spi_master #(
        .CLK_DIV  (4),
        .CS_SETUP (2),
        .CS_HOLD  (2),
        .CS_GAP   (4)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .regs       (regs),
        .spi_sclk_o (sclk),
        .spi_cs_n_o (cs_n),
        .spi_mosi_o (mosi),
        .spi_miso_i (miso)
    );

    always #(PERIOD/2) aclk = ~aclk;

    typedef struct {
        logic [31:0] frame;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    int          checks      = 0;
    int          errors      = 0;
    int          done_count  = 0;
    int          pushed      = 0;
    int          busy_cycles = 0;
    int          rise_cnt    = 0;
    int          rises_seen  = 0;
    int          gap_cycles  = 0;
    int          d0          = 0;
    bit          found       = 1'b0;
    time         t_sclk_fall = 0;
    logic [31:0] mosi_sh     = '0;
    logic [31:0] frame_seen  = '0;
    logic [31:0] miso_word   = 32'h00ABCDEF;
    logic [31:0] exp_rdata   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // MOSI capture on SCLK rise; frame summary latched when cs_n returns high
    always @(posedge sclk or posedge cs_n) begin
        if (cs_n) begin
            frame_seen = mosi_sh;
            rises_seen = rise_cnt;
            mosi_sh    = '0;
            rise_cnt   = 0;
        end else begin
            mosi_sh = {mosi_sh[30:0], mosi};
            rise_cnt++;
        end
    end

    always @(negedge cs_n or negedge sclk) begin
        if (cs_n == 1'b0) begin
            miso = (rise_cnt < 32) ? miso_word[5'(31 - rise_cnt)] : 1'b0;
        end
    end

    always @(negedge sclk) t_sclk_fall = $time;
    always @(negedge cs_n) gap_cycles = int'(($time - t_sclk_fall) / PERIOD);

    always @(negedge aclk) begin
        exp_t e;
        if (!aresetn) begin
            busy_cycles = 0;
        end else begin
            if (regs.busy_o) busy_cycles++;
            if (regs.done_o) begin
                done_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("mosi_frame", frame_seen, e.frame);
                    check("sclk_rises", 32'(rises_seen), 32'd32);
                    check("busy_cycles", 32'(busy_cycles), 32'(BUSY_CYCLES));
                    check("rdata", regs.rdata_o, e.rdata);
                end
                busy_cycles = 0;
            end
        end
    end

    task automatic push_exp(input logic rnw, input logic [6:0] addr, input logic [23:0] wdata);
        exp_t e;
        if (rnw) exp_rdata = {8'h00, miso_word[23:0]};
        e.frame = {rnw, addr, wdata};
        e.rdata = exp_rdata;
        exp_q.push_back(e);
        pushed++;
    endtask

    // Called at a negedge; strobe rises now and drops one cycle later with inputs scrambled
    task automatic launch(input logic rnw, input logic [6:0] addr, input logic [23:0] wdata,
                          input bit expect_frame);
        regs.rnw_i    = rnw;
        regs.addr_i   = addr;
        regs.wdata_i  = wdata;
        regs.strobe_i = 1'b1;
        if (expect_frame) push_exp(rnw, addr, wdata);
        @(negedge aclk);
        regs.strobe_i = 1'b0;
        regs.rnw_i    = ~rnw;
        regs.addr_i   = ~addr;
        regs.wdata_i  = ~wdata;
        if (expect_frame) begin
            check("launch_busy", 32'(regs.busy_o), 32'd1);
            check("launch_cs_n", 32'(cs_n), 32'd0);
            check("launch_mosi", 32'(mosi), 32'(rnw));
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            @(negedge aclk);
            if (!regs.busy_o) return;
        end
        check("wait_idle_timeout", 32'(regs.busy_o), 32'd0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000; i++) begin
            @(negedge aclk);
            if (regs.done_o) return;
        end
        check("wait_done_timeout", 32'(regs.done_o), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        regs.strobe_i = 1'b0;
        regs.rnw_i    = 1'b0;
        regs.addr_i   = '0;
        regs.wdata_i  = '0;
        repeat (3) @(negedge aclk);
        check("rst_busy", 32'(regs.busy_o), 32'd0);
        check("rst_done", 32'(regs.done_o), 32'd0);
        check("rst_rdata", regs.rdata_o, 32'd0);
        check("rst_overrun", 32'(regs.overrun_o), 32'd0);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_mosi", 32'(mosi), 32'd0);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        launch(1'b0, 7'h01, 24'h000003, 1'b1);
        wait_idle();
        launch(1'b1, 7'h02, 24'h000000, 1'b1);
        wait_idle();
        launch(1'b0, 7'h7F, 24'hA5A5A5, 1'b1);
        wait_idle();

        launch(1'b0, 7'h10, 24'h123456, 1'b1);
        repeat (48) @(negedge aclk);
        launch(1'b1, 7'h11, 24'hFFFFFF, 1'b0);
        check("overrun_set", 32'(regs.overrun_o), 32'd1);
        wait_idle();
        check("overrun_sticky", 32'(regs.overrun_o), 32'd1);
        launch(1'b0, 7'h20, 24'h0000FF, 1'b1);
        check("overrun_cleared", 32'(regs.overrun_o), 32'd0);
        wait_idle();

        miso_word     = 32'h00123456;
        d0            = done_count;
        regs.rnw_i    = 1'b1;
        regs.addr_i   = 7'h05;
        regs.wdata_i  = 24'h111111;
        regs.strobe_i = 1'b1;
        push_exp(1'b1, 7'h05, 24'h111111);
        repeat (1000) @(negedge aclk);
        regs.strobe_i = 1'b0;
        wait_idle();
        @(negedge aclk);
        check("held_one_done", 32'(done_count - d0), 32'd1);

        launch(1'b0, 7'h33, 24'h000033, 1'b1);
        wait_done();
        regs.strobe_i = 1'b1;
        @(negedge aclk);
        check("done_launch_overrun", 32'(regs.overrun_o), 32'd1);
        check("done_launch_idle", 32'(regs.busy_o), 32'd0);
        regs.strobe_i = 1'b0;
        repeat (3) @(negedge aclk);
        check("done_launch_no_frame", 32'(cs_n), 32'd1);

        launch(1'b0, 7'h44, 24'h444444, 1'b1);
        wait_idle();
        launch(1'b0, 7'h55, 24'h555555, 1'b1);
        check("b2b_gap_ge_hold_gap", 32'(gap_cycles >= 6), 32'd1);
        wait_idle();

        launch(1'b0, 7'h66, 24'h666666, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge aclk);
            if (rise_cnt >= 10 && sclk) found = 1'b1;
        end
        check("reset_point_reached", 32'(found), 32'd1);
        #2 aresetn = 1'b0;
        exp_rdata = '0;
        #1;
        check("async_rst_cs_n", 32'(cs_n), 32'd1);
        check("async_rst_sclk", 32'(sclk), 32'd0);
        check("async_rst_busy", 32'(regs.busy_o), 32'd0);
        check("async_rst_rdata", regs.rdata_o, 32'd0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        launch(1'b0, 7'h0A, 24'hBCDEF0, 1'b1);
        wait_idle();

        repeat (5) @(negedge aclk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("done_total", 32'(done_count), 32'(pushed));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
